muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative, parametrised RV32M-style multiply/divide unit for the multi-cycle core. Sits beside the
//  combinational ALU. The core's EXECUTE state hands it an R-type op with funct7=0000001 and stalls
//  until the result returns. Supports XLEN-generic operands, configurable bits-per-cycle, a
//  valid/ready handshake on both sides, and an abort (flush) input.
// PARAMETERS
//  XLEN    32  operand/result width; must be even and >= 8
//  UNROLL  1   iteration bits per cycle; must divide XLEN; N = XLEN/UNROLL RUN cycles
// PORTS
//  clk        in   1     clock; all state updates on the rising edge
//  resetn     in   1     reset; asynchronous, active-low
//  in_valid   in   1     request valid
//  in_ready   out  1     unit idle, able to accept a request
//  op         in   3     funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  a          in   XLEN  rs1 operand
//  b          in   XLEN  rs2 operand
//  flush      in   1     abort any in-flight op; result discarded
//  out_valid  out  1     result valid; held until out_ready
//  out_ready  in   1     consumer accepts the result
//  result     out  XLEN  result
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1, out_valid=0, result=0; all internal registers cleared.
//  - Accept when in_valid&&in_ready. Capture op, a and b at that edge. in_ready=1 only in IDLE.
//  - FSM: IDLE -> PREP -> RUN(N cycles) -> FIX -> DONE -> IDLE.
//    - PREP: take absolute values of signed operands. Record the result-sign flags.
//    - RUN: each cycle performs UNROLL shift-add steps (MUL*) or restoring-subtract steps (DIV*/REM*).
//      A down-counter runs N-1..0.
//    - FIX: negate the result if the sign flags require it. Select the high or low half / quotient
//      or remainder.
//    - DONE: out_valid=1 and result stable. On out_ready go to IDLE; in_ready rises the next cycle.
//  - Latency: out_valid asserts N+2 cycles after the accept edge (34 for XLEN=32, UNROLL=1).
//  - MUL returns the low XLEN bits of the product. MULH/MULHSU/MULHU return the high XLEN bits of
//    the 2*XLEN product (s*s, s*u, u*u).
//  - Divide by zero: quotient = all ones; remainder = a.
//  - Signed overflow (a=MIN, b=-1): quotient = MIN; remainder = 0.
//  - Remainder sign follows the dividend; quotient rounds toward zero.
//  - flush (any state except IDLE): next state IDLE; out_valid=0 the next cycle. flush has priority
//    over out_ready. flush in IDLE has no effect, and a same-cycle request is still accepted.
//  - resetn low mid-operation: immediate return to reset values; no partial result is ever presented.
//  - out_ready while out_valid=0 is ignored. Inputs a, b and op are don't-care outside the accept cycle.
// CONFIGURATION
//  MULDIV_FAST_SPECIAL_EN
//   - Defined: PREP detects divide-by-zero, signed overflow, and multiply with a or b = 0. It jumps
//     straight to DONE with the final result, so out_valid follows 2 cycles after the accept edge.
//   - Undefined: no shortcut. Every op takes N+2 cycles. The iterative path must still produce the
//     special-case results above, with bit-identical results in both builds.
// STRUCTURE
//  - Shared package/header muldiv_pkg: op encodings (MD_MUL..MD_REMU), FSM state encoding
//    (MD_IDLE..MD_DONE), MULDIV opcode/funct7 constants for core decode.
//  - Sub-module muldiv_step: combinational single-bit step (add/shift or trial-subtract). It is
//    instantiated UNROLL times in a generate chain; the FSM and counter stay in muldiv_unit.
// TESTING
//  - Reset mid-RUN of a DIVU -> in_ready=1, out_valid=0 and result=0 while resetn low and after release.
//  - XLEN=32, UNROLL=1: MUL 7*6 -> result=42, out_valid exactly 34 cycles after accept. Then
//    MULH 0x80000000*0x80000000 -> 0x40000000.
//  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF;
//    MULHU same operands -> 0xFFFFFFFE.
//  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM same -> 0.
//    Latency is 2 cycles with MULDIV_FAST_SPECIAL_EN, 34 without.
//  - Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and out_valid stable,
//    in_ready=0. Release -> in_ready=1 next cycle.
//  - flush during RUN cycle 10 -> out_valid never asserts. Next MULU 3*5 accepted -> 15 with
//    nominal latency. Repeat with UNROLL=4: latency 10.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and core-decode constants for muldiv_unit
package muldiv_pkg;
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } op_e;
  typedef enum logic [2:0] {
    MD_IDLE,
    MD_PREP,
    MD_RUN,
    MD_FIX,
    MD_DONE
  } state_e;
  localparam logic [6:0] MULDIV_OPCODE = 7'b0110011;
  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration, shift-add (multiply) or restoring trial-subtract (divide)
//   div        : 1 = divide step, 0 = multiply step
//   hi_i/lo_i  : {acc, multiplier} or {remainder, dividend/quotient} pair in
//   d_i        : multiplicand or divisor magnitude
//   hi_o/lo_o  : pair after one step
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);
  logic [XLEN:0] sum, sh, diff;
  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, d_i} : '0);
    sh   = {hi_i, lo_i[XLEN-1]};
    diff = sh - {1'b0, d_i};
    hi_o = div ? (diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
    lo_o = div ? {lo_i[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo_i[XLEN-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide, UNROLL steps per cycle, valid/ready + flush
//   in_valid/in_ready/op/a/b : request side (in_ready only in IDLE)
//   out_valid/out_ready/result : response side (held until out_ready)
//   flush : abort in-flight op; resetn : async active-low reset
//   MULDIV_FAST_SPECIAL_EN : when defined, divide-by-zero, signed overflow and zero-operand
//   multiplies skip the iteration and finish 2 cycles after accept
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int N  = XLEN / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic neg_q, neg_d, spec_q, spec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sgn_a, sgn_b, is_div, is_rem, b_zero;
  logic [XLEN-1:0] qr, qr_f;
  logic [2*XLEN-1:0] prod_f;
  logic [XLEN-1:0] hs [UNROLL+1];
  logic [XLEN-1:0] ls [UNROLL+1];
  assign hs[0] = hi_q;
  assign ls[0] = lo_q;
  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .div  (is_div),
      .hi_i (hs[i]),
      .lo_i (ls[i]),
      .d_i  (b_q),
      .hi_o (hs[i+1]),
      .lo_o (ls[i+1])
    );
  end
  assign in_ready  = state_q == MD_IDLE;
  assign out_valid = state_q == MD_DONE;
  assign result    = result_q;
  always_comb begin
    is_div = op_q[2];
    is_rem = op_q[2] & op_q[1];
    b_zero = b_q == '0;
    sgn_a  = (op_q == MD_MULH || op_q == MD_MULHSU || op_q == MD_DIV || op_q == MD_REM) && a_q[XLEN-1];
    sgn_b  = (op_q == MD_MULH || op_q == MD_DIV || op_q == MD_REM) && b_q[XLEN-1];
    prod_f = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    qr     = is_rem ? hi_q : lo_q;
    qr_f   = neg_q ? -qr : qr;
  end
`ifdef MULDIV_FAST_SPECIAL_EN
  logic ovf, spec_hit;
  logic [XLEN-1:0] spec_res;
  always_comb begin
    ovf      = is_div && !op_q[0] && a_q == {1'b1, {(XLEN-1){1'b0}}} && &b_q;
    spec_hit = is_div ? (b_zero || ovf) : (a_q == '0 || b_zero);
    spec_res = !is_div ? '0 : b_zero ? (is_rem ? a_q : '1) : (is_rem ? '0 : a_q);
  end
`endif
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    spec_d   = spec_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      MD_IDLE: if (in_valid) begin
        op_d    = op_e'(op);
        a_d     = a;
        b_d     = b;
        state_d = MD_PREP;
      end
      MD_PREP: begin
        hi_d    = '0;
        lo_d    = sgn_a ? -a_q : a_q;
        b_d     = sgn_b ? -b_q : b_q;
        // a zero divisor leaves the quotient at all ones, so it must never be negated
        neg_d   = !is_div ? sgn_a ^ sgn_b : is_rem ? sgn_a : (sgn_a ^ sgn_b) & !b_zero;
        cnt_d   = CW'(N - 1);
        spec_d  = 1'b0;
        state_d = MD_RUN;
`ifdef MULDIV_FAST_SPECIAL_EN
        // special result is parked in result_q; FIX then only advances to DONE
        if (spec_hit) begin
          spec_d   = 1'b1;
          result_d = spec_res;
          state_d  = MD_FIX;
        end
`endif
      end
      MD_RUN: begin
        hi_d    = hs[UNROLL];
        lo_d    = ls[UNROLL];
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? MD_FIX : MD_RUN;
      end
      MD_FIX: begin
        if (!spec_q)
          result_d = is_div ? qr_f : op_q == MD_MUL ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
        state_d = MD_DONE;
      end
      MD_DONE: if (out_ready) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (flush && state_q != MD_IDLE) state_d = MD_IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_MUL;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      spec_q   <= spec_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (UNROLL=1 and UNROLL=4 instances)
module tb_muldiv_unit;
  import muldiv_pkg::*;
`ifdef MULDIV_FAST_SPECIAL_EN
  localparam int LS = 2;
`else
  localparam int LS = 34;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic iv1 = 1'b0, iv4 = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic ir1, ov1, ir4, ov4;
  logic [31:0] res1, res4;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  muldiv_unit #(.XLEN(32), .UNROLL(1)) dut1 (
    .clk(clk), .resetn(resetn), .in_valid(iv1), .in_ready(ir1), .op(op), .a(a), .b(b),
    .flush(flush), .out_valid(ov1), .out_ready(out_ready), .result(res1)
  );
  muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk(clk), .resetn(resetn), .in_valid(iv4), .in_ready(ir4), .op(op), .a(a), .b(b),
    .flush(flush), .out_valid(ov4), .out_ready(out_ready), .result(res4)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input bit u4, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (u4) iv4 = 1'b1; else iv1 = 1'b1;
    op = o; a = x; b = y;
    @(posedge clk); #1;
    iv1 = 1'b0; iv4 = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; op = 3'b111;
  endtask
  task automatic wait_valid(input bit u4, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(u4 ? ov4 : ov1) && lat < 200);
  endtask
  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  task automatic do_op(input bit u4, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int exp_lat, input string tag);
    int lat;
    issue(u4, o, x, y);
    wait_valid(u4, lat);
    check(tag, u4 ? res4 : res1, exp);
    check({tag, "_lat"}, lat, exp_lat);
    take();
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int lat, cnt;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ir", ir1, 1);
    check("rst_ov", ov1, 0);
    check("rst_res", res1, 0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    do_op(0, MD_MUL,    32'd7,        32'd6,        32'd42,       34, "mul_7x6");
    do_op(0, MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh_min");
    do_op(0, MD_DIV,    -32'sd7,      32'd2,        32'hFFFF_FFFD, 34, "div_m7_2");
    do_op(0, MD_REM,    -32'sd7,      32'd2,        32'hFFFF_FFFF, 34, "rem_m7_2");
    do_op(0, MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu_ff");
    do_op(0, MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_ff");
    do_op(0, MD_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34, "mul_ff");
    do_op(0, MD_DIV,    32'd7,        -32'sd2,      32'hFFFF_FFFD, 34, "div_7_m2");
    do_op(0, MD_REM,    32'd7,        -32'sd2,      32'd1,        34, "rem_7_m2");
    do_op(0, MD_DIVU,   32'd100,      32'd7,        32'd14,       34, "divu_100_7");
    do_op(0, MD_REMU,   32'd17,       32'd5,        32'd2,        34, "remu_17_5");
    do_op(0, MD_DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, LS, "divu_by0");
    do_op(0, MD_REM,    32'd5,        32'd0,        32'd5,        LS, "rem_by0");
    do_op(0, MD_DIV,    -32'sd5,      32'd0,        32'hFFFF_FFFF, LS, "div_neg_by0");
    do_op(0, MD_REM,    -32'sd5,      32'd0,        32'hFFFF_FFFB, LS, "rem_neg_by0");
    do_op(0, MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LS, "div_ovf");
    do_op(0, MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        LS, "rem_ovf");
    do_op(0, MD_MULH,   32'h1234_5678, 32'd0,        32'd0,        LS, "mulh_zero");
    // backpressure
    issue(0, MD_MUL, 32'd3, 32'd4);
    wait_valid(0, lat);
    check("bp_lat", lat, 34);
    for (int k = 0; k < 5; k++) begin
      check("bp_ov", ov1, 1);
      check("bp_res", res1, 12);
      check("bp_ir", ir1, 0);
      @(posedge clk); #1;
    end
    take();
    check("bp_rel_ir", ir1, 1);
    check("bp_rel_ov", ov1, 0);
    // flush during RUN cycle 10
    issue(0, MD_DIVU, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_ov", ov1, 0);
    check("fl_ir", ir1, 1);
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov1) cnt++;
    end
    check("fl_never_valid", cnt, 0);
    do_op(0, MD_MUL, 32'd3, 32'd5, 32'd15, 34, "fl_mul_3x5");
    // flush in IDLE does not block a same-cycle request
    flush = 1'b1;
    issue(0, MD_MUL, 32'd2, 32'd3);
    flush = 1'b0;
    wait_valid(0, lat);
    check("idle_fl_res", res1, 6);
    check("idle_fl_lat", lat, 34);
    take();
    // UNROLL=4 instance
    do_op(1, MD_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, 10, "u4_div");
    do_op(1, MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 10, "u4_mulhu");
    issue(1, MD_DIVU, 32'd1000, 32'd7);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ov4) cnt++;
    end
    check("u4_fl_never_valid", cnt, 0);
    do_op(1, MD_MUL, 32'd3, 32'd5, 32'd15, 10, "u4_mul_3x5");
    // reset mid-RUN of a DIVU
    issue(0, MD_DIVU, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("mrst_ir", ir1, 1);
    check("mrst_ov", ov1, 0);
    check("mrst_res", res1, 0);
    @(negedge clk) resetn = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov1) cnt++;
    end
    check("mrst_never_valid", cnt, 0);
    check("mrst_ir_after", ir1, 1);
    check("mrst_res_after", res1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
